dataselect_rr_reg: RTL and testbench

- Parametrised successor to the plain 2:1 32-bit data selector.
- Selects one of CHANNELS input words, either by explicit control (fixed mode) or by round-robin arbitration among valid inputs.
- Registers the result behind a valid/ready output handshake.
- Used where several datapath sources (ALU result, memory data, immediate, PC) compete for one register-file or bus write port across multicycle states.

---
 rtl/dataselect_rr_reg.sv | 156 +++++++++++++++
 tb/tb_dataselect_rr_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dataselect_rr_reg.sv
// dataselect_rr_reg: selects one of CHANNELS input words, by explicit ctrl
// (fixed mode) or by round-robin among valid inputs. The result sits in an
// output register behind a valid/ready handshake.
// Optional feature: define DATASELECT_STALL_CNT_EN to add a saturating
// 16-bit counter of backpressure cycles (port stall_cnt).
module dataselect_rr_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          ctrl,
    output logic [WIDTH-1:0]          data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
`ifdef DATASELECT_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] chan_q,  chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load_s;
    logic             grant_vld_s;
    logic [SEL_W-1:0] grant_s;
    logic [WIDTH-1:0] data_sel_s;
    logic             xfer_s;

    // Output register can accept a word when it is empty or being drained.
    assign load_s = !valid_q || out_ready;

    // Grant selection: ctrl in fixed mode, first valid after rr_ptr in RR mode.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
        if (mode == 1'b0) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ctrl == SEL_W'(i) && in_valid[i]) begin
                    grant_vld_s = 1'b1;
                    grant_s     = SEL_W'(i);
                end else begin
                end
            end
        end else begin
            // Walk the scan order backwards so the nearest valid channel
            // after the pointer is the last (winning) assignment.
            for (int k = CHANNELS; k >= 1; k--) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (((int'(rr_ptr_q) + k) % CHANNELS) == i && in_valid[i]) begin
                        grant_vld_s = 1'b1;
                        grant_s     = SEL_W'(i);
                    end else begin
                    end
                end
            end
        end
    end

    // Mux the granted channel's word out of the flat input bus.
    always_comb begin
        data_sel_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_s == SEL_W'(i)) begin
                data_sel_s = data_in[i*WIDTH +: WIDTH];
            end else begin
            end
        end
    end

    // One-hot accept strobe; forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && load_s && grant_vld_s && (grant_s == SEL_W'(i));
        end
    end

    // A grant only exists for a valid channel, so grant plus load is a transfer.
    assign xfer_s = rst_n && load_s && grant_vld_s;

    // Next-state for output register and round-robin pointer.
    always_comb begin
        data_d   = data_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer_s) begin
            data_d  = data_sel_s;
            chan_d  = grant_s;
            valid_d = 1'b1;
            if (mode == 1'b1) begin
                rr_ptr_d = grant_s;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; pointer resets to the last channel so channel 0 leads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= SEL_W'(CHANNELS - 1);
        end else begin
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign out_chan  = chan_q;

`ifdef DATASELECT_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles where a held word is blocked by the consumer.
    always_comb begin
        if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_dataselect_rr_reg.sv
// Directed self-checking bench for dataselect_rr_reg (WIDTH=32, CHANNELS=4).
module tb_dataselect_rr_reg;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          ctrl;
    logic [WIDTH-1:0]          data_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;
`ifdef DATASELECT_STALL_CNT_EN
    logic [15:0]               stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] dat [4];

    dataselect_rr_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .ctrl      (ctrl),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
`ifdef DATASELECT_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq_a [8];
        int seq_b [4];
        seq_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        seq_b = '{1, 3, 1, 3};
        dat[0] = 32'h1111_0000;
        dat[1] = 32'h2222_0001;
        dat[2] = 32'hDEAD_BEEF;
        dat[3] = 32'h4444_0003;
        data_in   = {dat[3], dat[2], dat[1], dat[0]};
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        ctrl      = 2'd0;
        out_ready = 1'b1;

        // Reset state with valid inputs pending
        tick();
        tick();
        chk("rst_data",   data_out,  32'h0);
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_chan",   {30'd0, out_chan},  32'd0);
        chk("rst_ready",  {28'd0, in_ready},  32'd0);
        rst_n = 1'b1;

        // Fixed mode, ctrl=2
        mode = 1'b0; ctrl = 2'd2; in_valid = 4'b0100;
        #1;
        chk("fix_ready2", {28'd0, in_ready}, 32'h4);
        tick();
        chk("fix_data2",  data_out, 32'hDEAD_BEEF);
        chk("fix_chan2",  {30'd0, out_chan},  32'd2);
        chk("fix_valid2", {31'd0, out_valid}, 32'd1);
        ctrl = 2'd3;
        #1;
        chk("fix_ready3", {28'd0, in_ready}, 32'h0);
        tick();
        chk("fix_drain",  {31'd0, out_valid}, 32'd0);
        chk("fix_hold",   data_out, 32'hDEAD_BEEF);

        // Round-robin, all valid: pointer still at reset value 3
        mode = 1'b1; in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr_all_chan%0d", c), {30'd0, out_chan}, 32'(seq_a[c]));
            chk($sformatf("rr_all_data%0d", c), data_out, dat[seq_a[c]]);
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rr_1010_chan%0d", c), {30'd0, out_chan}, 32'(seq_b[c]));
        end

        // Backpressure: pointer at 3, holding channel 3
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", {28'd0, in_ready}, 32'h0);
            tick();
            chk("bp_chan",  {30'd0, out_chan},  32'd3);
            chk("bp_data",  data_out, dat[3]);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, in_ready}, 32'h1);
        tick();
        chk("bp_release_chan",  {30'd0, out_chan},  32'd0);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd1);

        // Mode switch: RR grants 1, two fixed transfers of ch0, back to RR -> 2
        tick();
        chk("ms_rr1", {30'd0, out_chan}, 32'd1);
        mode = 1'b0; ctrl = 2'd0;
        tick();
        chk("ms_fix_a", {30'd0, out_chan}, 32'd0);
        tick();
        chk("ms_fix_b", data_out, dat[0]);
        mode = 1'b1;
        #1;
        chk("ms_rr_ready", {28'd0, in_ready}, 32'h4);
        tick();
        chk("ms_rr2", {30'd0, out_chan}, 32'd2);

        // Asynchronous reset mid-stream with a held word
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data",  data_out, 32'h0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_chan",  {30'd0, out_chan},  32'd0);
        chk("arst_ready", {28'd0, in_ready},  32'h0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("post_rst_chan0", {30'd0, out_chan}, 32'd0);
        chk("post_rst_data0", data_out, dat[0]);

`ifdef DATASELECT_STALL_CNT_EN
        // Stall counter counts and saturates, cleared by reset
        out_ready = 1'b0;
        repeat (5) tick();
        chk("stall_5", {16'd0, stall_cnt}, 32'd5);
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        tick();
        chk("stall_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        rst_n = 1'b0;
        #1;
        chk("stall_rst", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
